counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Programmable sequencer for a bank of three small up-counters (A, B, C). It runs the counters strictly in order, A to its limit, then B, then C, for a programmable number of passes. It supports a start/done handshake, pause and abort. It is the control block that owns the counter bank: limits and pass count are latched at start, and the counter values are exported for downstream checking/display.

## Interface

- W, 3, counter width (A/B/C and limits)
- PW, 4, pass-count width

- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  request a run; sampled only in IDLE
- lim_a, lim_b, lim_c  in  W each  terminal values, latched on accepted start
- loops  in  PW  number of passes, latched on accepted start; 0 treated as 1
- pause  in  1  freeze counters and state while high (RUN_*/WRAP only)
- abort  in  1  terminate run; priority over pause
- a, b, c  out  W each  counter values
- phase  out  2  0=A, 1=B, 2=C, 3=idle/wrap/done
- pass_cnt  out  PW  completed passes in current run
- busy  out  1  high in RUN_A/RUN_B/RUN_C/WRAP
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on accepted abort

## Operation

- States: IDLE, RUN_A, RUN_B, RUN_C, WRAP, DONE.
- Reset: state IDLE, a=b=c=0, pass_cnt=0, busy=done=aborted=0, phase=3, latched limits=0, latched loops=1.
- IDLE: when start=1, latch lim_*/loops, clear a,b,c,pass_cnt, go RUN_A. When start=0, hold; counters keep their last values.
- RUN_X (X=A/B/C): if counter==lim_X, no increment, advance (A->B, B->C). Otherwise increment by 1 and stay. Counters never wrap inside a run, because the limit is reached first.
- RUN_C at limit: if pass_cnt+1 == loops_eff, increment pass_cnt and go DONE. Otherwise increment pass_cnt and go WRAP.
- WRAP: clear a,b,c; next RUN_A. Lasts 1 cycle.
- DONE: done=1 for this cycle; next IDLE. Counters hold their final values.
- pause=1 in RUN_*/WRAP: state, counters and pass_cnt hold. No effect in IDLE/DONE.
- abort=1 in RUN_*/WRAP: next state IDLE, counters and pass_cnt hold, aborted=1 for one cycle (registered, concurrent with IDLE). Abort is ignored in IDLE/DONE.
- start while not IDLE is ignored. Limits and loops changing mid-run have no effect.
- Limit 0: the state occupies exactly 1 cycle with no increment.
- Reset mid-run forces the full reset state on the next edge, with no done/aborted pulse.

## Timing

- All outputs are registered; the only flops are the state register, counters, pass_cnt, latches and the pulse flops.
- Start accepted at edge T0 gives busy=1 after T0.
- One pass occupies lim_a+lim_b+lim_c+3 cycles. Each WRAP between passes adds 1 cycle.
- Single pass with limits 5/6/7:
  - a increments at T1..T5
  - RUN_B entered after T6
  - b increments at T7..T12
  - RUN_C entered after T13
  - c increments at T14..T20
  - DONE entered after T21 (done=1, busy=0)
  - IDLE entered after T22
- Earliest restart: start sampled in IDLE at T22+1.
- Each pause cycle extends the timeline by exactly 1 cycle.

## Structure

- Package counter_seq_pkg holds:
  - state enum (IDLE, RUN_A, RUN_B, RUN_C, WRAP, DONE)
  - phase encoding constants (PH_A=0, PH_B=1, PH_C=2, PH_NONE=3)
  - default W/PW
- Sub-module counter_unit, instantiated 3×:
  - inputs: clk, reset, clr, en, lim
  - outputs: q, at_lim (q==lim, combinational)
- The top level contains the FSM, latches, pass counter and pulse generation.

## Test plan

- Limits 5/6/7, loops=1, start pulse at T0: done pulses after T21 only; final a=5, b=6, c=7, pass_cnt=1; busy high for exactly 21 cycles.
- Limits 0/0/0, loops=1: each RUN state lasts 1 cycle, done after T3, counters stay 0.
- Limits 1/2/3, loops=3: counters cleared during the WRAP cycles; pass_cnt steps 1,2,3; done after 3×9+2 cycles; final a=1, b=2, c=3.
- Limits 5/6/7, pause high 4 cycles while b=3: b holds at 3, then completes; done at T25; start asserted mid-run is ignored.
- Limits 5/6/7, abort when c=2: aborted pulse only, c stays 2, busy=0, no done. Then a new start runs normally.
- Reset asserted while b=4: next cycle state IDLE, all counters 0, no done or aborted pulse.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the A/B/C counter sequencer.
package counter_seq_pkg;

    localparam int CNT_W  = 3;
    localparam int PASS_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN_A = 3'd1,
        RUN_B = 3'd2,
        RUN_C = 3'd3,
        WRAP  = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_C    = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

endpackage

// File: rtl/counter_seq_ctrl_counter_unit.sv
// Small up-counter with clear, enable and terminal-value compare.
module counter_unit #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic [W-1:0] q,
    output logic         at_lim
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_lim = (q_q == lim);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer running counters A, B, C in order for a programmable
// number of passes, with start/done handshake, pause and abort.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int W  = CNT_W,
    parameter int PW = PASS_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  lim_a,
    input  logic [W-1:0]  lim_b,
    input  logic [W-1:0]  lim_c,
    input  logic [PW-1:0] loops,
    input  logic          pause,
    input  logic          abort,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic [W-1:0]  c,
    output logic [1:0]    phase,
    output logic [PW-1:0] pass_cnt,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    seq_state_t    state_d, state_q;
    logic [W-1:0]  lim_a_d, lim_a_q;
    logic [W-1:0]  lim_b_d, lim_b_q;
    logic [W-1:0]  lim_c_d, lim_c_q;
    logic [PW-1:0] loops_d, loops_q;
    logic [PW-1:0] pass_d, pass_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic          aborted_d, aborted_q;
    logic [1:0]    phase_d, phase_q;

    logic          clr;
    logic          en_a, en_b, en_c;
    logic          at_a, at_b, at_c;
    logic          active;
    logic [PW:0]   pass_inc;
    logic          last_pass;

    counter_unit #(.W(W)) u_cnt_a (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .en     (en_a),
        .lim    (lim_a_q),
        .q      (a),
        .at_lim (at_a)
    );

    counter_unit #(.W(W)) u_cnt_b (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .en     (en_b),
        .lim    (lim_b_q),
        .q      (b),
        .at_lim (at_b)
    );

    counter_unit #(.W(W)) u_cnt_c (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .en     (en_c),
        .lim    (lim_c_q),
        .q      (c),
        .at_lim (at_c)
    );

    assign active = (state_q == RUN_A) || (state_q == RUN_B) ||
                    (state_q == RUN_C) || (state_q == WRAP);

    // Wide compare so a full-scale loop count cannot alias.
    assign pass_inc  = {1'b0, pass_q} + {{PW{1'b0}}, 1'b1};
    assign last_pass = (pass_inc == {1'b0, loops_q});

    always_comb begin
        state_d   = state_q;
        lim_a_d   = lim_a_q;
        lim_b_d   = lim_b_q;
        lim_c_d   = lim_c_q;
        loops_d   = loops_q;
        pass_d    = pass_q;
        clr       = 1'b0;
        en_a      = 1'b0;
        en_b      = 1'b0;
        en_c      = 1'b0;
        aborted_d = 1'b0;

        if (active && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else if (!(active && pause)) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        lim_a_d = lim_a;
                        lim_b_d = lim_b;
                        lim_c_d = lim_c;
                        loops_d = (loops == '0) ? PW'(1) : loops;
                        pass_d  = '0;
                        clr     = 1'b1;
                        state_d = RUN_A;
                    end
                end
                RUN_A: begin
                    if (at_a) state_d = RUN_B;
                    else      en_a    = 1'b1;
                end
                RUN_B: begin
                    if (at_b) state_d = RUN_C;
                    else      en_b    = 1'b1;
                end
                RUN_C: begin
                    if (at_c) begin
                        pass_d  = pass_inc[PW-1:0];
                        state_d = last_pass ? DONE : WRAP;
                    end else begin
                        en_c = 1'b1;
                    end
                end
                WRAP: begin
                    clr     = 1'b1;
                    state_d = RUN_A;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN_A) || (state_d == RUN_B) ||
                 (state_d == RUN_C) || (state_d == WRAP);
        done_d = (state_d == DONE);

        unique case (state_d)
            RUN_A:   phase_d = PH_A;
            RUN_B:   phase_d = PH_B;
            RUN_C:   phase_d = PH_C;
            default: phase_d = PH_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lim_a_q   <= '0;
            lim_b_q   <= '0;
            lim_c_q   <= '0;
            loops_q   <= PW'(1);
            pass_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            phase_q   <= PH_NONE;
        end else begin
            state_q   <= state_d;
            lim_a_q   <= lim_a_d;
            lim_b_q   <= lim_b_d;
            lim_c_q   <= lim_c_d;
            loops_q   <= loops_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            phase_q   <= phase_d;
        end
    end

    assign pass_cnt = pass_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: vector table of full runs plus
// hand-written pause, abort and reset sequences.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] lim_a, lim_b, lim_c;
    logic [3:0] loops;
    logic       pause;
    logic       abort;
    logic [2:0] a, b, c;
    logic [1:0] phase;
    logic [3:0] pass_cnt;
    logic       busy, done, aborted;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int la, lb, lc, lp;
        int done_at;
        int ea, eb, ec, ep;
    } vec_t;

    vec_t vecs[5];

    counter_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lim_a    (lim_a),
        .lim_b    (lim_b),
        .lim_c    (lim_c),
        .loops    (loops),
        .pause    (pause),
        .abort    (abort),
        .a        (a),
        .b        (b),
        .c        (c),
        .phase    (phase),
        .pass_cnt (pass_cnt),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive limits and a start pulse; returns just after edge T0.
    task automatic launch(input int la, input int lb, input int lc,
                          input int lp);
        lim_a = 3'(la);
        lim_b = 3'(lb);
        lim_c = 3'(lc);
        loops = 4'(lp);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int t, nb, wraps;
        bit found, prev_wrap;
        t = 0; nb = 0; wraps = 0;
        found = 0; prev_wrap = 0;
        launch(v.la, v.lb, v.lc, v.lp);
        for (int k = 0; k < 300; k++) begin
            if (prev_wrap) chk("wrap_clear", int'(a) + int'(b) + int'(c), 0);
            prev_wrap = busy && (phase == 2'd3);
            if (prev_wrap) begin
                wraps++;
                chk("wrap_pass", int'(pass_cnt), wraps);
            end
            if (busy) nb++;
            if (done) begin
                found = 1;
                break;
            end
            tick();
            t++;
        end
        chk("done_seen", int'(found), 1);
        chk("done_at", t, v.done_at);
        chk("busy_cycles", nb, v.done_at);
        chk("final_a", int'(a), v.ea);
        chk("final_b", int'(b), v.eb);
        chk("final_c", int'(c), v.ec);
        chk("final_pass", int'(pass_cnt), v.ep);
        chk("busy_at_done", int'(busy), 0);
        tick();
        chk("done_width", int'(done), 0);
        chk("idle_phase", int'(phase), 3);
    endtask

    // Step until counter sel (0=a,1=b,2=c) equals val; returns edge index.
    task automatic wait_cnt(input int sel, input int val, inout int t);
        bit hit;
        hit = 0;
        for (int k = 0; k < 100; k++) begin
            if ((sel == 0 && int'(a) == val) ||
                (sel == 1 && int'(b) == val) ||
                (sel == 2 && int'(c) == val)) begin
                hit = 1;
                break;
            end
            tick();
            t++;
        end
        chk("wait_cnt_hit", int'(hit), 1);
    endtask

    initial begin
        int t;
        bit seen;

        vecs[0] = '{la:5, lb:6, lc:7, lp:1, done_at:21, ea:5, eb:6, ec:7, ep:1};
        vecs[1] = '{la:0, lb:0, lc:0, lp:1, done_at:3,  ea:0, eb:0, ec:0, ep:1};
        vecs[2] = '{la:1, lb:2, lc:3, lp:3, done_at:29, ea:1, eb:2, ec:3, ep:3};
        vecs[3] = '{la:7, lb:7, lc:7, lp:0, done_at:24, ea:7, eb:7, ec:7, ep:1};
        vecs[4] = '{la:2, lb:0, lc:1, lp:2, done_at:13, ea:2, eb:0, ec:1, ep:2};

        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        lim_a = '0; lim_b = '0; lim_c = '0;
        loops = '0;
        tick();
        tick();
        chk("rst_a", int'(a), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_phase", int'(phase), 3);
        chk("rst_pulses", int'(done) + int'(aborted), 0);
        reset = 1'b0;
        tick();
        chk("idle_hold_busy", int'(busy), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Pause for 4 cycles while b=3; a mid-run start must be ignored.
        t = 0;
        launch(5, 6, 7, 1);
        wait_cnt(1, 3, t);
        chk("pause_at", t, 9);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            t++;
            chk("pause_b", int'(b), 3);
            chk("pause_phase", int'(phase), 1);
        end
        pause = 1'b0;
        start = 1'b1;
        lim_c = 3'd2;
        tick();
        t++;
        tick();
        t++;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            tick();
            t++;
        end
        chk("pause_done_seen", int'(seen), 1);
        chk("pause_done_at", t, 25);
        chk("pause_final_b", int'(b), 6);
        chk("pause_final_c", int'(c), 7);
        tick();

        // Abort when c=2.
        t = 0;
        launch(5, 6, 7, 1);
        wait_cnt(2, 2, t);
        chk("abort_at", t, 15);
        abort = 1'b1;
        pause = 1'b1;
        tick();
        abort = 1'b0;
        pause = 1'b0;
        chk("aborted_pulse", int'(aborted), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_c", int'(c), 2);
        chk("abort_phase", int'(phase), 3);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) seen = 1;
            tick();
        end
        chk("abort_no_done", int'(seen), 0);
        chk("aborted_width", int'(aborted), 0);
        chk("abort_hold_c", int'(c), 2);
        run_vec(vecs[0]);

        // Reset mid-run while b=4.
        t = 0;
        launch(5, 6, 7, 2);
        wait_cnt(1, 4, t);
        chk("reset_at", t, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_abc", int'(a) + int'(b) + int'(c), 0);
        chk("rst_mid_pass", int'(pass_cnt), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pulses", int'(done) + int'(aborted), 0);
        tick();
        chk("rst_mid_stays_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
